fmap_stream_ctrl: RTL and testbench
===================================

# fmap_stream_ctrl

Sequencing controller for the convolution feature-map stream register. Scans one IMG_HEIGHT x IMG_WIDTH frame in raster order, handshakes pixels from upstream, produces the load enable (`features_valid`) for the stream register, and flags every position where a complete KERNEL_SIZE x KERNEL_SIZE window is available to the convolution engine. One frame per `start`.

## Interface
- IMG_WIDTH, 28, pixels per row (>= KERNEL_SIZE)
- IMG_HEIGHT, 28, rows per frame (>= KERNEL_SIZE)
- KERNEL_SIZE, 5, convolution window edge
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a frame; honoured only in IDLE
- in_valid  input  1  upstream pixel vector present
- in_ready  output  1  controller accepts pixel this cycle
- out_ready  input  1  convolution engine can take a new window
- features_valid  output  1  load enable to stream register (= transfer)
- window_valid  output  1  stream register now holds the bottom-right pixel of a full window
- win_row  output  $clog2(IMG_HEIGHT-KERNEL_SIZE+1)  output-map row of current window
- win_col  output  $clog2(IMG_WIDTH-KERNEL_SIZE+1)  output-map column of current window
- busy  output  1  state != IDLE
- frame_done  output  1  one-cycle pulse after last pixel accepted

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: counters row/col held at 0; in_ready = 0. start = 1 -> STREAM next cycle.
- STREAM: in_ready = out_ready (combinational). Transfer = in_valid && in_ready; features_valid = transfer (combinational, same cycle, so stream register captures that edge).
- On transfer: col increments; at col = IMG_WIDTH-1 col wraps to 0 and row increments. Transfer at (IMG_HEIGHT-1, IMG_WIDTH-1) -> row/col to 0, state -> DONE.
- No transfer: counters hold; no bubbles inserted or pixels dropped.
- DONE: one cycle, frame_done = 1, in_ready = 0, then IDLE. start in DONE ignored.
- start in STREAM ignored (no restart mid-frame).
- window_valid registered: set on the edge following a transfer whose (row,col) satisfies row >= KERNEL_SIZE-1 and col >= KERNEL_SIZE-1; cleared on every other edge. Thus aligned with the stream register output.
- win_row/win_col registered with window_valid: row-(KERNEL_SIZE-1), col-(KERNEL_SIZE-1) of that transfer; hold last value otherwise.
- Windows per frame: (IMG_HEIGHT-KERNEL_SIZE+1)*(IMG_WIDTH-KERNEL_SIZE+1).
- Counter widths: $clog2(IMG_WIDTH), $clog2(IMG_HEIGHT); comparisons unsigned; no overflow by construction.

## Timing
- Reset values: state IDLE, row = col = 0, window_valid 0, win_row 0, win_col 0, frame_done 0, busy 0; in_ready and features_valid 0 (IDLE).
- rst asserted mid-frame: immediate return to IDLE, all outputs to reset values, partial frame discarded; next frame needs new start.
- start at edge N -> busy and in_ready-eligible from cycle N+1.
- Transfer at edge T -> window_valid/win_* visible after edge T (cycle T+1), one cycle only unless next cycle is also a qualifying transfer.
- Last transfer at edge L -> frame_done high in cycle L+1 (DONE), busy drops cycle L+2; earliest new start sampled in cycle L+2.
- Back-to-back throughput: one pixel per cycle when in_valid and out_ready both held high.
- out_ready low: in_ready low same cycle, counters and window outputs frozen except window_valid clears.

## Test plan
- Reset: rst pulse mid-run, all outputs at reset values while asserted, in_ready = 0 with in_valid = 1.
- Full frame, in_valid = out_ready = 1 from start (28x28, K=5): 784 features_valid pulses, frame_done exactly one cycle after 784th transfer, 576 window_valid pulses, first after transfer index 116 with win_row=0, win_col=0, last after index 783 with win_row=23, win_col=23.
- Backpressure: random 50% out_ready and in_valid: transfer count still 784, window_valid count 576, win_* sequence strictly raster, no transfer while out_ready = 0.
- Row wrap: after transfer at (4,27) win_col=23 with window_valid; next transfer (5,0) gives window_valid = 0.
- start during STREAM and DONE ignored: counters undisturbed, single frame_done; start in IDLE after frame begins new frame at (0,0).
- Reset at transfer 300: controller IDLE, no frame_done; subsequent start yields clean full frame with 784 transfers.

Source files
------------

// File: rtl/fmap_stream_ctrl.sv
// Raster-scan sequencer for the convolution feature-map stream register.
// Handshakes one pixel per transfer and flags each position that completes a full KxK window.
module fmap_stream_ctrl #(
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28,
    parameter int KERNEL_SIZE = 5,
    localparam int WR_W = $clog2(IMG_HEIGHT - KERNEL_SIZE + 1),
    localparam int WC_W = $clog2(IMG_WIDTH - KERNEL_SIZE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            out_ready,
    output logic            features_valid,
    output logic            window_valid,
    output logic [WR_W-1:0] win_row,
    output logic [WC_W-1:0] win_col,
    output logic            busy,
    output logic            frame_done
);

    // state  | meaning
    // IDLE   | waiting for start, counters parked at (0,0)
    // STREAM | accepting pixels in raster order while out_ready allows
    // DONE   | single cycle after the last pixel, frame_done asserted

    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_K1   = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0] COL_K1   = COL_W'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t           state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             transfer;

    // Ready follows the engine combinationally so a stalled engine never loses a pixel.
    assign in_ready       = (state == STREAM) && out_ready;
    assign transfer       = in_valid && in_ready;
    assign features_valid = transfer;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            window_valid <= 1'b0;
            win_row      <= '0;
            win_col      <= '0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            case (state)
                IDLE: begin
                    row <= '0;
                    col <= '0;
                    if (start) state <= STREAM;
                end
                STREAM: begin
                    if (transfer) begin
                        // Window outputs line up with the stream register, one edge after the load.
                        if (row >= ROW_K1 && col >= COL_K1) begin
                            window_valid <= 1'b1;
                            win_row      <= WR_W'(row - ROW_K1);
                            win_col      <= WC_W'(col - COL_K1);
                        end
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row        <= '0;
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_stream_ctrl.sv
// Scoreboard bench for fmap_stream_ctrl: driver models the raster scan and queues
// expected window results, a monitor pops them whenever the DUT loads a pixel.
module tb_fmap_stream_ctrl;

    localparam int W = 28;
    localparam int H = 28;
    localparam int K = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       features_valid;
    logic       window_valid;
    logic [4:0] win_row;
    logic [4:0] win_col;
    logic       busy;
    logic       frame_done;

    fmap_stream_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .features_valid(features_valid), .window_valid(window_valid),
        .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit wv;
        int wr;
        int wc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Independent reference model of the scan
    int m_state = 0;   // 0 idle, 1 stream, 2 done
    int m_row = 0;
    int m_col = 0;
    int m_xfers = 0;

    int xfer_cnt = 0;
    int win_cnt = 0;
    int fd_cnt = 0;
    bit prev_fv = 1'b0;
    bit [15:0] lfsr = 16'hACE1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_fv = 1'b0;
        end else begin
            if (prev_fv) begin
                if (q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("window_valid", int'(window_valid), int'(e.wv));
                    if (e.wv) begin
                        chk("win_row", int'(win_row), e.wr);
                        chk("win_col", int'(win_col), e.wc);
                    end
                end
            end else begin
                chk("window_valid_idle", int'(window_valid), 0);
            end
            if (window_valid) win_cnt++;
            if (features_valid) xfer_cnt++;
            if (frame_done) fd_cnt++;
            prev_fv = features_valid;
        end
    end

    // One clock: drive at posedge+1, check at negedge, advance the model at posedge.
    task automatic step(input logic st, input logic iv, input logic ordy);
        bit x;
        start = st; in_valid = iv; out_ready = ordy;
        @(negedge clk);
        x = (m_state == 1) && iv && ordy;
        chk("in_ready", int'(in_ready), int'(m_state == 1 && ordy));
        chk("features_valid", int'(features_valid), int'(x));
        chk("busy", int'(busy), int'(m_state != 0));
        chk("frame_done", int'(frame_done), int'(m_state == 2));
        if (x) begin
            exp_t e;
            e.wv = (m_row >= K - 1) && (m_col >= K - 1);
            e.wr = m_row - (K - 1);
            e.wc = m_col - (K - 1);
            q.push_back(e);
        end
        @(posedge clk);
        case (m_state)
            0: if (st) m_state = 1;
            1: if (x) begin
                m_xfers++;
                if (m_col == W - 1) begin
                    m_col = 0;
                    if (m_row == H - 1) begin
                        m_row = 0;
                        m_state = 2;
                    end else m_row++;
                end else m_col++;
            end
            default: m_state = 0;
        endcase
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; start = 1'b0;
        q.delete();
        m_state = 0; m_row = 0; m_col = 0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_features_valid", int'(features_valid), 0);
        chk("rst_window_valid", int'(window_valid), 0);
        chk("rst_win_row", int'(win_row), 0);
        chk("rst_win_col", int'(win_col), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
    endtask

    // mode 0: full rate, 1: pseudo-random backpressure, 2: start held during STREAM/DONE
    task automatic run_frame(input int mode, input int abort_at);
        int  guard;
        bit  aborted;
        logic iv, ordy;
        xfer_cnt = 0; win_cnt = 0; fd_cnt = 0; m_xfers = 0;
        aborted = 1'b0;
        guard = 0;
        step(1'b1, 1'b1, 1'b1);
        while (m_state != 0 && guard < 20000) begin
            if (abort_at >= 0 && m_xfers == abort_at) begin
                do_reset();
                aborted = 1'b1;
                break;
            end
            iv = 1'b1; ordy = 1'b1;
            if (mode == 1) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                iv = lfsr[0];
                ordy = lfsr[7];
            end
            step(mode == 2, iv, ordy);
            guard++;
        end
        if (guard >= 20000) chk("frame_timeout", guard, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        if (aborted) begin
            chk("abort_frame_done_count", fd_cnt, 0);
            chk("abort_busy", int'(busy), 0);
        end else begin
            chk("transfer_count", xfer_cnt, W * H);
            chk("window_count", win_cnt, (H - K + 1) * (W - K + 1));
            chk("frame_done_count", fd_cnt, 1);
            chk("scoreboard_empty", q.size(), 0);
            chk("win_row_hold", int'(win_row), H - K);
            chk("win_col_hold", int'(win_col), W - K);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        run_frame(0, -1);
        run_frame(1, -1);
        // rst pulse mid-run with in_valid high
        run_frame(0, 40);
        run_frame(2, -1);
        run_frame(0, -1);
        run_frame(1, 300);
        run_frame(0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
